// File: rtl/instruction_memory_if.sv
// Fetch and program-load bus between the PC/decoder side and the instruction store.
// The CPU or loader drives the master modport; the memory uses the slave modport.
interface instruction_memory_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] PC;
    logic [DATA_WIDTH-1:0] instruction;
    logic                  addr_err;
    logic                  load_en;
    logic [ADDR_WIDTH-1:0] load_addr;
    logic [DATA_WIDTH-1:0] load_data;

    modport master (
        output PC,
        output load_en,
        output load_addr,
        output load_data,
        input  instruction,
        input  addr_err
    );

    modport slave (
        input  PC,
        input  load_en,
        input  load_addr,
        input  load_data,
        output instruction,
        output addr_err
    );
endinterface

// File: rtl/instruction_memory.sv
// Word-addressed instruction store with a combinational fetch path and a clocked load port.
// Per-word valid flops hide unloaded or reset-invalidated words behind NOP_WORD.
module instruction_memory #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DEPTH      = 256,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD   = 16'h0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    instruction_memory_if.slave   bus
);
    localparam int                    IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [DEPTH-1:0]      valid_r;

    logic                  rd_in_range_s;
    logic [IDX_W-1:0]      rd_idx_s;
    logic                  wr_en_s;
    logic [IDX_W-1:0]      wr_idx_s;
    logic [DATA_WIDTH-1:0] instruction_s;

    assign rd_in_range_s = (bus.PC < DEPTH_A);
    assign rd_idx_s      = bus.PC[IDX_W-1:0];
    assign wr_idx_s      = bus.load_addr[IDX_W-1:0];

    // Out-of-range load addresses are dropped rather than wrapped onto a legal word.
    assign wr_en_s = rst_n && bus.load_en && (bus.load_addr < DEPTH_A);

    // Valid bits: cleared asynchronously by reset, set by each accepted load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= '0;
        end else if (wr_en_s) begin
            valid_r[wr_idx_s] <= 1'b1;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Data array: never reset, its contents are masked by the valid bits.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_idx_s] <= bus.load_data;
        end
    end

    // Combinational fetch; no bypass of load_data so a same-address write shows after the edge.
    always_comb begin
        instruction_s = NOP_WORD;
        if (rd_in_range_s && valid_r[rd_idx_s]) begin
            instruction_s = mem_r[rd_idx_s];
        end else begin
            instruction_s = NOP_WORD;
        end
    end

    assign bus.instruction = instruction_s;
    assign bus.addr_err    = !rd_in_range_s;
endmodule

// File: tb/tb_instruction_memory.sv
// Directed self-checking bench for instruction_memory: fetch path, loads, boundaries and reset.
module tb_instruction_memory;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    instruction_memory_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) bus ();

    instruction_memory #(
        .DATA_WIDTH(16),
        .ADDR_WIDTH(16),
        .DEPTH(256),
        .NOP_WORD(16'h0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] load_vals [6];
    initial begin
        load_vals[0] = 16'h1234;
        load_vals[1] = 16'h5678;
        load_vals[2] = 16'h9ABC;
        load_vals[3] = 16'hDEF0;
        load_vals[4] = 16'h0F0F;
        load_vals[5] = 16'hF0F0;
    end

    // Present one load over a full clock period, centred on a rising edge.
    task automatic load_word(input logic [15:0] addr, input logic [15:0] data);
        @(negedge clk);
        bus.load_en   = 1'b1;
        bus.load_addr = addr;
        bus.load_data = data;
        @(negedge clk);
        bus.load_en   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (bus.instruction !== 16'h0000) begin
            errors++;
            $display("FAIL reset_hold instruction=%h expected=%h", bus.instruction, 16'h0000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.PC = 16'(i);
            #1;
            checks++;
            if (bus.instruction !== 16'h0000) begin
                errors++;
                $display("FAIL reset_sweep pc=%0d instruction=%h expected=%h", i, bus.instruction, 16'h0000);
            end
            checks++;
            if (bus.addr_err !== 1'b0) begin
                errors++;
                $display("FAIL reset_sweep_err pc=%0d addr_err=%b expected=0", i, bus.addr_err);
            end
        end
    endtask

    task automatic test_load_sweep();
        for (int i = 0; i < 6; i++) begin
            load_word(16'(i), load_vals[i]);
        end
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            bus.PC = 16'(i);
            #1;
            checks++;
            if (bus.instruction !== load_vals[i]) begin
                errors++;
                $display("FAIL load_sweep pc=%0d instruction=%h expected=%h", i, bus.instruction, load_vals[i]);
            end
        end
    endtask

    task automatic test_same_addr();
        @(negedge clk);
        bus.PC        = 16'd3;
        bus.load_en   = 1'b1;
        bus.load_addr = 16'd3;
        bus.load_data = 16'hAAAA;
        #1;
        checks++;
        if (bus.instruction !== 16'hDEF0) begin
            errors++;
            $display("FAIL same_addr_before instruction=%h expected=%h", bus.instruction, 16'hDEF0);
        end
        @(posedge clk);
        #1;
        bus.load_en = 1'b0;
        checks++;
        if (bus.instruction !== 16'hAAAA) begin
            errors++;
            $display("FAIL same_addr_after instruction=%h expected=%h", bus.instruction, 16'hAAAA);
        end
    endtask

    task automatic test_boundary();
        load_word(16'd255, 16'hBEEF);
        bus.PC = 16'd255;
        #1;
        checks++;
        if (bus.instruction !== 16'hBEEF || bus.addr_err !== 1'b0) begin
            errors++;
            $display("FAIL top_word instruction=%h addr_err=%b expected=beef/0", bus.instruction, bus.addr_err);
        end
        bus.PC = 16'd256;
        #1;
        checks++;
        if (bus.instruction !== 16'h0000 || bus.addr_err !== 1'b1) begin
            errors++;
            $display("FAIL past_end instruction=%h addr_err=%b expected=0000/1", bus.instruction, bus.addr_err);
        end
        bus.PC = 16'hFFFF;
        #1;
        checks++;
        if (bus.instruction !== 16'h0000 || bus.addr_err !== 1'b1) begin
            errors++;
            $display("FAIL pc_max instruction=%h addr_err=%b expected=0000/1", bus.instruction, bus.addr_err);
        end
        load_word(16'd300, 16'h1111);
        // 300 would alias onto word 44 if the load address wrapped.
        bus.PC = 16'd44;
        #1;
        checks++;
        if (bus.instruction !== 16'h0000) begin
            errors++;
            $display("FAIL oob_load_alias instruction=%h expected=%h", bus.instruction, 16'h0000);
        end
        bus.PC = 16'd300;
        #1;
        checks++;
        if (bus.instruction !== 16'h0000 || bus.addr_err !== 1'b1) begin
            errors++;
            $display("FAIL oob_load_read instruction=%h addr_err=%b expected=0000/1", bus.instruction, bus.addr_err);
        end
        bus.PC = 16'd255;
        #1;
        checks++;
        if (bus.instruction !== 16'hBEEF) begin
            errors++;
            $display("FAIL oob_load_top instruction=%h expected=%h", bus.instruction, 16'hBEEF);
        end
    endtask

    task automatic test_reset_midload();
        @(negedge clk);
        bus.PC = 16'd2;
        #1;
        checks++;
        if (bus.instruction !== 16'h9ABC) begin
            errors++;
            $display("FAIL pre_reset instruction=%h expected=%h", bus.instruction, 16'h9ABC);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.instruction !== 16'h0000 || bus.addr_err !== 1'b0) begin
            errors++;
            $display("FAIL async_clear instruction=%h addr_err=%b expected=0000/0", bus.instruction, bus.addr_err);
        end
        bus.load_en   = 1'b1;
        bus.load_addr = 16'd7;
        bus.load_data = 16'h7777;
        @(negedge clk);
        bus.load_en = 1'b0;
        #1;
        rst_n = 1'b1;
        bus.PC = 16'd7;
        #1;
        checks++;
        if (bus.instruction !== 16'h0000) begin
            errors++;
            $display("FAIL load_in_reset instruction=%h expected=%h", bus.instruction, 16'h0000);
        end
        for (int i = 0; i < 6; i++) begin
            bus.PC = 16'(i);
            #1;
            checks++;
            if (bus.instruction !== 16'h0000) begin
                errors++;
                $display("FAIL post_reset pc=%0d instruction=%h expected=%h", i, bus.instruction, 16'h0000);
            end
        end
    endtask

    task automatic test_reload();
        load_word(16'd2, 16'h4321);
        bus.PC = 16'd2;
        #1;
        checks++;
        if (bus.instruction !== 16'h4321) begin
            errors++;
            $display("FAIL reload instruction=%h expected=%h", bus.instruction, 16'h4321);
        end
        bus.PC = 16'd1;
        #1;
        checks++;
        if (bus.instruction !== 16'h0000) begin
            errors++;
            $display("FAIL reload_neighbor instruction=%h expected=%h", bus.instruction, 16'h0000);
        end
        bus.PC = 16'd255;
        #1;
        checks++;
        if (bus.instruction !== 16'h0000) begin
            errors++;
            $display("FAIL reload_top instruction=%h expected=%h", bus.instruction, 16'h0000);
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.PC        = 16'h0000;
        bus.load_en   = 1'b0;
        bus.load_addr = 16'h0000;
        bus.load_data = 16'h0000;
        test_reset();
        test_load_sweep();
        test_same_addr();
        test_boundary();
        test_reset_midload();
        test_reload();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
